sklansky_sum_stage: RTL and testbench
=====================================

Name: sklansky_sum_stage

Overview:
- Pipelined post-processing stage directly downstream of the 32-bit Sklansky carry generator.
- Consumes the per-bit propagate vector and the prefix carry vector (Carry[i] = carry out of bit i, carry-in 0).
- Produces the registered sum plus the flags carry-out, signed overflow, zero and negative.
- Presents a valid/ready handshake toward the ALU result mux, with a 2-deep skid buffer so that in_ready is a registered signal.

Parameters:
- WIDTH, 32, datapath width; must equal the carry generator width, so only 32 is supported.
- TAG_W, 4, width of the opaque op tag carried alongside each result.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  P/Carry/tag inputs are valid this cycle.
- in_ready  out  1  stage can accept an input this cycle; driven from a flop.
- in_p  in  WIDTH  propagate vector, P[i] = A[i] xor B[i].
- in_carry  in  WIDTH  prefix carry vector from the generator.
- in_tag  in  TAG_W  op tag, passed through unchanged.
- out_valid  out  1  result fields are valid.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  WIDTH  sum.
- out_cout  out  1  carry out of the MSB.
- out_ovf  out  1  signed overflow.
- out_zero  out  1  sum == 0.
- out_neg  out  1  sum[WIDTH-1].
- out_tag  out  TAG_W  tag of the result.
- busy  out  1  any entry is held in the stage.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: out_valid=0; in_ready=1; busy=0; out_sum, out_cout, out_ovf, out_zero, out_neg and out_tag all 0; skid buffer empty.
- Arithmetic, evaluated at capture (combinational from the inputs, then flopped):
  - sum[0] = P[0].
  - sum[i] = P[i] xor Carry[i-1] for i = 1..31.
  - cout = Carry[31].
  - ovf = Carry[31] xor Carry[30].
  - zero = (sum == 0).
  - neg = sum[31].
  - A result is one record: {sum, flags, tag}.
- Handshake: an input transfers when in_valid & in_ready. An output transfers when out_valid & out_ready.
- Storage: output register OR plus skid register SK; occupancy count 0..2. States and transitions:
  - EMPTY (count 0): out_valid=0, in_ready=1. Input transfer -> load OR -> ONE.
  - ONE (count 1): out_valid=1, in_ready=1.
    - Input and output transfer in the same cycle: OR <= new record; stay ONE.
    - Output only -> EMPTY.
    - Input only (out_ready=0): SK <= new record -> FULL.
  - FULL (count 2): out_valid=1, in_ready=0.
    - Output transfer: OR <= SK -> ONE.
    - in_valid is ignored; no capture.
- Latency and throughput: 1 cycle from input transfer to out_valid when the stage is empty. Sustains 1 result/cycle while out_ready=1.
- Ordering: strict FIFO; results never reorder or drop.
- Stability: OR fields are stable while out_valid & !out_ready.
- in_ready is the registered value (count<2 for the next cycle); no combinational path from out_ready to in_ready.
- busy = (count != 0).
- Reset mid-operation: all held records are discarded and the outputs return to their reset values on the next edge; inputs presented during rst are ignored.
- in_valid with X data while in_ready=0 must not disturb state.

Decomposition:
- Shared package sklansky_pkg:
  - ADDER_W=32 constant.
  - Result record typedef {sum, cout, ovf, zero, neg, tag}.
  - Occupancy state enum {EMPTY, ONE, FULL}.
- One natural sub-module: sklansky_sum_logic, the combinational P/Carry -> record function. It is reused by the skid path and by the bench's reference model.

Test Plan:
- Directed add of A=0x0000_0001, B=0x0000_0001 (P=0x0, Carry=0x1), out_ready=1 -> next cycle out_sum=0x2, cout=0, ovf=0, zero=0, neg=0.
- A=0xFFFF_FFFF, B=0x1 (P=0xFFFF_FFFE, Carry=0xFFFF_FFFF) -> sum=0x0, cout=1, ovf=0, zero=1.
- A=B=0x7FFF_FFFF (P=0, Carry=0x7FFF_FFFF) -> sum=0xFFFF_FFFE, ovf=1, neg=1, cout=0.
- Back-pressure:
  - Stimulus: out_ready=0, then 3 consecutive in_valid with tags 1, 2, 3.
  - Required: tags 1 and 2 are accepted; in_ready=0 on the cycle after the second capture; tag 3 is held off.
  - Then out_ready=1: outputs appear in order 1, 2, 3, with no loss and no duplicate.
- Streaming: 100 random operands with in_valid=1, out_ready=1 -> one result per cycle matching the reference model, and in_ready stays 1.
- Reset mid-operation: assert rst while in FULL -> next cycle out_valid=0, in_ready=1, busy=0, all outputs 0; the first post-reset input emerges with latency 1.

Source files
------------

// File: rtl/sklansky_pkg.sv
// Shared types for the Sklansky sum stage: adder width, result record and
// occupancy states of the output/skid storage.
package sklansky_pkg;

  localparam int ADDER_W   = 32;
  localparam int REC_TAG_W = 4;

  typedef struct packed {
    logic [ADDER_W-1:0]   sum;
    logic                 cout;
    logic                 ovf;
    logic                 zero;
    logic                 neg;
    logic [REC_TAG_W-1:0] tag;
  } sum_rec_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_state_t;

endpackage

// File: rtl/sklansky_sum_logic.sv
// Combinational P/Carry -> result record. Carry[i] is the carry out of bit i
// with carry-in 0, so bit i of the sum uses the carry out of bit i-1.
module sklansky_sum_logic
  import sklansky_pkg::*;
(
  input  logic [ADDER_W-1:0]   p,
  input  logic [ADDER_W-1:0]   carry,
  input  logic [REC_TAG_W-1:0] tag,
  output sum_rec_t             rec
);

  logic [ADDER_W-1:0] sum;

  // Sum and flags; ovf compares carry into and out of the sign bit.
  always_comb begin
    sum      = p ^ {carry[ADDER_W-2:0], 1'b0};
    rec.sum  = sum;
    rec.cout = carry[ADDER_W-1];
    rec.ovf  = carry[ADDER_W-1] ^ carry[ADDER_W-2];
    rec.zero = (sum == '0);
    rec.neg  = sum[ADDER_W-1];
    rec.tag  = tag;
  end

endmodule

// File: rtl/sklansky_sum_stage.sv
// Registered sum/flag stage behind the 32-bit Sklansky carry generator, with
// a two-entry (output + skid) buffer so in_ready comes straight from a flop.
//
// state | meaning
// EMPTY | nothing held, out_valid=0, in_ready=1
// ONE   | result in OR only, out_valid=1, in_ready=1
// FULL  | results in OR and SK, out_valid=1, in_ready=0
//
// Only WIDTH=32 and TAG_W=4 are meaningful: the record layout is fixed by
// the carry generator width.
module sklansky_sum_stage
  import sklansky_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_p,
  input  logic [WIDTH-1:0] in_carry,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero,
  output logic             out_neg,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  sum_rec_t   in_rec;
  sum_rec_t   or_q;
  sum_rec_t   sk_q;
  occ_state_t state;
  occ_state_t state_nxt;
  logic       load_or_in;
  logic       load_or_sk;
  logic       load_sk;
  logic       in_ready_q;
  logic       out_valid_q;
  logic       busy_q;

  sklansky_sum_logic u_sum_logic (
    .p     (in_p),
    .carry (in_carry),
    .tag   (in_tag),
    .rec   (in_rec)
  );

  // Next occupancy and which register captures what; in_valid is only
  // looked at in states that advertise in_ready.
  always_comb begin
    state_nxt  = state;
    load_or_in = 1'b0;
    load_or_sk = 1'b0;
    load_sk    = 1'b0;
    case (state)
      EMPTY: begin
        if (in_valid) begin
          load_or_in = 1'b1;
          state_nxt  = ONE;
        end
      end
      ONE: begin
        if (in_valid && out_ready) begin
          load_or_in = 1'b1;
        end else if (in_valid) begin
          load_sk   = 1'b1;
          state_nxt = FULL;
        end else if (out_ready) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (out_ready) begin
          load_or_sk = 1'b1;
          state_nxt  = ONE;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // Storage and registered handshake/status flags derived from next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= EMPTY;
      or_q        <= '0;
      sk_q        <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load_or_in) begin
        or_q <= in_rec;
      end else if (load_or_sk) begin
        or_q <= sk_q;
      end
      if (load_sk) begin
        sk_q <= in_rec;
      end
      in_ready_q  <= (state_nxt != FULL);
      out_valid_q <= (state_nxt != EMPTY);
      busy_q      <= (state_nxt != EMPTY);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_sum   = or_q.sum;
  assign out_cout  = or_q.cout;
  assign out_ovf   = or_q.ovf;
  assign out_zero  = or_q.zero;
  assign out_neg   = or_q.neg;
  assign out_tag   = or_q.tag;

endmodule

// File: tb/tb_sklansky_sum_stage.sv
// Self-checking bench for sklansky_sum_stage. Operands A/B are turned into
// P/Carry here; expected results come from plain 33-bit addition and a FIFO
// queue model of the stage's occupancy.
module tb_sklansky_sum_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_p;
  logic [31:0] in_carry;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sum;
  logic        out_cout;
  logic        out_ovf;
  logic        out_zero;
  logic        out_neg;
  logic [3:0]  out_tag;
  logic        busy;

  int errors = 0;
  int checks = 0;

  // expected record: {sum[31:0], cout, ovf, zero, neg, tag[3:0]}
  logic [39:0] exp_q[$];
  logic [3:0]  popped_tags[$];

  always #5 clk = ~clk;

  sklansky_sum_stage #(.WIDTH(32), .TAG_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_p      (in_p),
    .in_carry  (in_carry),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .out_zero  (out_zero),
    .out_neg   (out_neg),
    .out_tag   (out_tag),
    .busy      (busy)
  );

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // Carry out of bit i = bit i+1 of the sum of the low i+1 bits of A and B.
  function automatic logic [31:0] carry_of(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] c;
    logic [63:0] m;
    logic [63:0] s;
    for (int i = 0; i < 32; i++) begin
      m = (64'd1 << (i + 1)) - 64'd1;
      s = ({32'd0, a} & m) + ({32'd0, b} & m);
      c[i] = s[i+1];
    end
    return c;
  endfunction

  function automatic logic [39:0] ref_rec(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] t);
    logic [32:0] s;
    logic        ovf;
    s   = {1'b0, a} + {1'b0, b};
    ovf = (a[31] == b[31]) && (s[31] != a[31]);
    return {s[31:0], s[32], ovf, (s[31:0] == 32'd0), s[31], t};
  endfunction

  // One clock of stimulus: checks the registered outputs against the model,
  // scores any output/input transfer, then advances to #1 after the edge.
  task automatic cycle(input bit v, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] t, input bit ordy);
    int          sz;
    logic [39:0] e;
    in_valid  = v;
    in_p      = a ^ b;
    in_carry  = carry_of(a, b);
    in_tag    = t;
    out_ready = ordy;
    sz = exp_q.size();
    check("in_ready", {63'd0, in_ready}, {63'd0, (sz < 2)});
    check("out_valid", {63'd0, out_valid}, {63'd0, (sz > 0)});
    check("busy", {63'd0, busy}, {63'd0, (sz > 0)});
    if (sz > 0 && ordy) begin
      e = exp_q.pop_front();
      check("out_sum", {32'd0, out_sum}, {32'd0, e[39:8]});
      check("out_cout", {63'd0, out_cout}, {63'd0, e[7]});
      check("out_ovf", {63'd0, out_ovf}, {63'd0, e[6]});
      check("out_zero", {63'd0, out_zero}, {63'd0, e[5]});
      check("out_neg", {63'd0, out_neg}, {63'd0, e[4]});
      check("out_tag", {60'd0, out_tag}, {60'd0, e[3:0]});
      popped_tags.push_back(out_tag);
    end
    if (v && sz < 2) exp_q.push_back(ref_rec(a, b, t));
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_out_valid"}, {63'd0, out_valid}, 64'd0);
    check({name, "_in_ready"}, {63'd0, in_ready}, 64'd1);
    check({name, "_busy"}, {63'd0, busy}, 64'd0);
    check({name, "_fields"}, {24'd0, out_sum, out_cout, out_ovf, out_zero, out_neg, out_tag},
          64'd0);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    rst = 1'b1; in_valid = 1'b0; in_p = '0; in_carry = '0; in_tag = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    // directed adds, each drained on the following cycle
    cycle(1'b1, 32'h0000_0001, 32'h0000_0001, 4'h1, 1'b1);
    check("dir1_sum", {32'd0, out_sum}, 64'h2);
    check("dir1_flags", {60'd0, out_cout, out_ovf, out_zero, out_neg}, 64'h0);
    cycle(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 4'h2, 1'b1);
    check("dir2_sum", {32'd0, out_sum}, 64'h0);
    check("dir2_flags", {60'd0, out_cout, out_ovf, out_zero, out_neg}, 64'b1010);
    cycle(1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 4'h3, 1'b1);
    check("dir3_sum", {32'd0, out_sum}, 64'hFFFF_FFFE);
    check("dir3_flags", {60'd0, out_cout, out_ovf, out_zero, out_neg}, 64'b0101);
    cycle(1'b0, 32'd0, 32'd0, 4'h0, 1'b1);

    // back-pressure: tags 1, 2 captured, 3 held off
    popped_tags.delete();
    cycle(1'b1, 32'd10, 32'd1, 4'd1, 1'b0);
    cycle(1'b1, 32'd20, 32'd2, 4'd2, 1'b0);
    check("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
    cycle(1'b1, 32'd30, 32'd3, 4'd3, 1'b0);
    // garbage offered while full must not be captured
    cycle(1'b1, $urandom, $urandom, 4'hF, 1'b0);
    check("bp_out_tag_hold", {60'd0, out_tag}, 64'd1);
    cycle(1'b1, 32'd30, 32'd3, 4'd3, 1'b1);
    cycle(1'b1, 32'd30, 32'd3, 4'd3, 1'b1);
    cycle(1'b0, 32'd0, 32'd0, 4'd0, 1'b1);
    cycle(1'b0, 32'd0, 32'd0, 4'd0, 1'b1);
    check("bp_count", 64'(popped_tags.size()), 64'd3);
    if (popped_tags.size() == 3)
      check("bp_order", {52'd0, popped_tags[0], popped_tags[1], popped_tags[2]}, 64'h123);

    // streaming random operands
    for (int i = 0; i < 100; i++) begin
      a = $urandom;
      b = $urandom;
      if (i % 10 == 3) b = ~a + 32'd1;
      if (i % 10 == 7) begin a = 32'h8000_0000 | a; b = 32'h8000_0000 | b; end
      cycle(1'b1, a, b, 4'($urandom_range(0, 15)), 1'b1);
    end
    cycle(1'b0, 32'd0, 32'd0, 4'd0, 1'b1);
    cycle(1'b0, 32'd0, 32'd0, 4'd0, 1'b1);
    check("stream_drained", 64'(exp_q.size()), 64'd0);

    // reset while full
    cycle(1'b1, 32'd5, 32'd6, 4'd7, 1'b0);
    cycle(1'b1, 32'd7, 32'd8, 4'd8, 1'b0);
    check("pre_rst_full", {63'd0, in_ready}, 64'd0);
    rst = 1'b1;
    in_valid = 1'b1;
    in_p = $urandom;
    in_carry = $urandom;
    in_tag = 4'h9;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    check_reset_outputs("mid_reset");
    cycle(1'b1, 32'h1234_5678, 32'h1111_1111, 4'hA, 1'b1);
    check("post_rst_latency", {63'd0, out_valid}, 64'd1);
    check("post_rst_sum", {32'd0, out_sum}, 64'h2345_6789);
    cycle(1'b0, 32'd0, 32'd0, 4'd0, 1'b1);
    cycle(1'b0, 32'd0, 32'd0, 4'd0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
